// File: rtl/mips_pkg.sv
// Shared definitions for the register file and its read ports.
package mips_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam int ZERO_REG_ADDR = 0;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: zero register, write-through bypass, array.
module regfile_read_port
    import mips_pkg::*;
#(
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int ADDR_W = mips_pkg::REG_ADDR_W,
    parameter int ZERO_REG = 1,
    localparam int NUM_REGS = 2 ** ADDR_W
) (
    input  logic [ADDR_W-1:0]                 addr,
    input  logic [NUM_REGS-1:0][DATA_W-1:0]   mem,
    input  logic [NUM_REGS-1:0]               pend_bits,
    input  logic                              we,
    input  logic [ADDR_W-1:0]                 waddr,
    input  logic [DATA_W-1:0]                 wdata,
    output logic [DATA_W-1:0]                 data,
    output logic                              pending
);
    logic is_zero;

    assign is_zero = (ZERO_REG != 0) && (addr == ADDR_W'(ZERO_REG_ADDR));

    always_comb begin
        data = mem[addr];
        pending = pend_bits[addr];
        if (is_zero) begin
            data = '0;
            pending = 1'b0;
        end else if (we && (waddr == addr)) begin
            // Bypass: a WB write is visible to ID in the same cycle
            data = wdata;
            pending = 1'b0;
        end
    end
endmodule

// File: rtl/mips_regfile_scoreboard.sv
// Register file with N bypassed read ports and a per-register pending scoreboard.
module mips_regfile_scoreboard
    import mips_pkg::*;
#(
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int ADDR_W = mips_pkg::REG_ADDR_W,
    parameter int NUM_RD = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic [NUM_RD*ADDR_W-1:0] ReadRegister,
    output logic [NUM_RD*DATA_W-1:0] ReadData,
    output logic [NUM_RD-1:0]        ReadPending,
    input  logic                     RegWrite,
    input  logic [ADDR_W-1:0]        WriteRegister,
    input  logic [DATA_W-1:0]        WriteData,
    input  logic                     IssueValid,
    input  logic [ADDR_W-1:0]        IssueRegister,
    output logic                     AnyPending
);
    localparam int NUM_REGS = 2 ** ADDR_W;

    logic [NUM_REGS-1:0][DATA_W-1:0] mem;
    logic [NUM_REGS-1:0]             pending;
    logic                            wr_ok;
    logic                            iss_ok;

    assign wr_ok = RegWrite &&
        !((ZERO_REG != 0) && (WriteRegister == ADDR_W'(ZERO_REG_ADDR)));
    assign iss_ok = IssueValid &&
        !((ZERO_REG != 0) && (IssueRegister == ADDR_W'(ZERO_REG_ADDR)));

    always_ff @(posedge Clk) begin
        if (Reset) begin
            mem <= '0;
            pending <= '0;
        end else begin
            if (wr_ok) begin
                mem[WriteRegister] <= WriteData;
                pending[WriteRegister] <= 1'b0;
            end
            // Issue after write: a new producer wins over the retiring one
            if (iss_ok) begin
                pending[IssueRegister] <= 1'b1;
            end
        end
    end

    assign AnyPending = |pending;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        regfile_read_port #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .ZERO_REG (ZERO_REG)
        ) u_port (
            .addr      (ReadRegister[k*ADDR_W +: ADDR_W]),
            .mem       (mem),
            .pend_bits (pending),
            .we        (RegWrite),
            .waddr     (WriteRegister),
            .wdata     (WriteData),
            .data      (ReadData[k*DATA_W +: DATA_W]),
            .pending   (ReadPending[k])
        );
    end
endmodule
